// File: rtl/jk_sync_counter.sv
// Mod-MODULUS up/down counter held in a bank of JK flip-flops driven by minimal excitation.
// Define JK_CNT_SATURATE_EN to hold at the count limits instead of wrapping.
module jk_sync_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             load_err
);

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] nxt;
  logic             load_ok;
  logic             at_max;
  logic             at_zero;

  function automatic logic jk_next(input logic cur, input logic jb, input logic kb);
    case ({jb, kb})
      2'b10:   jk_next = 1'b1;
      2'b01:   jk_next = 1'b0;
      2'b11:   jk_next = ~cur;
      default: jk_next = cur;
    endcase
  endfunction

  assign load_ok = {1'b0, load_val} < MOD_EXT;
  assign at_max  = (q == MAX_VAL);
  assign at_zero = (q == '0);

  always_comb begin
    nxt = q;
    if (load) begin
      nxt = load_ok ? load_val : '0;
    end else if (en) begin
`ifdef JK_CNT_SATURATE_EN
      if (up_dn) nxt = at_max ? q : q + WIDTH'(1);
      else       nxt = at_zero ? q : q - WIDTH'(1);
`else
      if (up_dn) nxt = at_max ? '0 : q + WIDTH'(1);
      else       nxt = at_zero ? MAX_VAL : q - WIDTH'(1);
`endif
    end
  end

  // Minimal excitation: only bits that change get a set or clear, never a toggle.
  assign j  = nxt & ~q;
  assign k  = ~nxt & q;
  assign tc = en & ~load & (up_dn ? at_max : at_zero);
  assign Q  = ~q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        q[i] <= jk_next(q[i], j[i], k[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) load_err <= 1'b0;
    else     load_err <= load & ~load_ok;
  end

endmodule
